// File: rtl/voice_allocator_pkg.sv
// Shared types for the polyphony scheduler.
//   note_status_t  : MIDI-style ON/OFF event status
//   note_change_t  : one note event (status + 7-bit note number)
//   voice_index_t  : voice index for the default voice count
package voice_allocator_pkg;

  localparam int NUM_VOICES_DEFAULT = 8;
  localparam int NOTE_WIDTH         = 7;

  typedef enum logic {
    NOTE_OFF = 1'b0,
    NOTE_ON  = 1'b1
  } note_status_t;

  typedef struct packed {
    note_status_t            status;
    logic [NOTE_WIDTH-1:0]   note_number;
  } note_change_t;

  typedef logic [$clog2(NUM_VOICES_DEFAULT)-1:0] voice_index_t;

endpackage

// File: rtl/voice_allocator_select.sv
// Combinational voice search for the allocator.
//   active       : per-voice sounding flag
//   note_numbers : note held by each voice
//   ages         : per-voice age counters
//   query        : note number of the incoming event
//   match_hit/match_idx : an active voice already holds query (lowest index)
//   free_hit/free_idx   : lowest-index inactive voice
//   oldest_idx          : voice with maximum age, ties to the lowest index
module voice_select
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEFAULT,
  parameter int AGE_WIDTH  = 4,
  localparam int IDX_W     = $clog2(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0] active,
  input  logic [NOTE_WIDTH-1:0] note_numbers [NUM_VOICES],
  input  logic [AGE_WIDTH-1:0]  ages [NUM_VOICES],
  input  logic [NOTE_WIDTH-1:0] query,
  output logic                  match_hit,
  output logic [IDX_W-1:0]      match_idx,
  output logic                  free_hit,
  output logic [IDX_W-1:0]      free_idx,
  output logic [IDX_W-1:0]      oldest_idx
);

  logic [AGE_WIDTH-1:0] best_age;

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active[i] && (note_numbers[i] == query)) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
      if (!active[i]) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Strict greater-than keeps the earlier (lower) index on equal ages.
  always_comb begin
    best_age   = ages[0];
    oldest_idx = '0;
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (ages[i] > best_age) begin
        best_age   = ages[i];
        oldest_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: maps incoming note events onto NUM_VOICES pipelines.
//   clock_50_000_000 : system clock
//   reset_l          : asynchronous active-low reset
//   note/note_ready  : one note event per strobe
//   all_off          : panic, silences every sounding voice
//   voice_note       : registered per-voice note state (held between strobes)
//   voice_ready      : one-cycle per-voice strobe
//   active_mask      : voices currently holding a sounding note
//   stolen           : one-cycle pulse when an ON evicted a sounding voice
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEFAULT,
  parameter int AGE_WIDTH  = 4
) (
  input  logic                  clock_50_000_000,
  input  logic                  reset_l,
  input  note_change_t          note,
  input  logic                  note_ready,
  input  logic                  all_off,
  output note_change_t          voice_note [NUM_VOICES],
  output logic [NUM_VOICES-1:0] voice_ready,
  output logic [NUM_VOICES-1:0] active_mask,
  output logic                  stolen
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  logic [AGE_WIDTH-1:0]  ages        [NUM_VOICES];
  logic [AGE_WIDTH-1:0]  ages_n      [NUM_VOICES];
  logic [NOTE_WIDTH-1:0] note_numbers[NUM_VOICES];
  note_change_t          voice_note_n[NUM_VOICES];
  logic [NUM_VOICES-1:0] voice_ready_n;
  logic [NUM_VOICES-1:0] active_n;
  logic                  stolen_n;

  logic                  match_hit;
  logic                  free_hit;
  logic [IDX_W-1:0]      match_idx;
  logic [IDX_W-1:0]      free_idx;
  logic [IDX_W-1:0]      oldest_idx;
  logic [IDX_W-1:0]      target;

  // The registered voice_note already records the note each voice holds.
  always_comb begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      note_numbers[i] = voice_note[i].note_number;
    end
  end

  voice_select #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_WIDTH  (AGE_WIDTH)
  ) u_select (
    .active       (active_mask),
    .note_numbers (note_numbers),
    .ages         (ages),
    .query        (note.note_number),
    .match_hit    (match_hit),
    .match_idx    (match_idx),
    .free_hit     (free_hit),
    .free_idx     (free_idx),
    .oldest_idx   (oldest_idx)
  );

  // Next-state for the voice table. all_off wins over a coincident event;
  // ON picks retrigger, then free, then steal; unmatched OFF is ignored.
  always_comb begin
    active_n      = active_mask;
    ages_n        = ages;
    voice_note_n  = voice_note;
    voice_ready_n = '0;
    stolen_n      = 1'b0;
    target        = '0;

    if (all_off) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (active_mask[i]) begin
          active_n[i]      = 1'b0;
          ages_n[i]        = '0;
          voice_ready_n[i] = 1'b1;
          voice_note_n[i]  = '{status: NOTE_OFF, note_number: voice_note[i].note_number};
        end
      end
    end else if (note_ready) begin
      if (note.status == NOTE_ON) begin
        if (match_hit) begin
          target = match_idx;
        end else if (free_hit) begin
          target = free_idx;
        end else begin
          target   = oldest_idx;
          stolen_n = 1'b1;
        end
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (active_mask[i] && (IDX_W'(i) != target) && (ages[i] != AGE_MAX)) begin
            ages_n[i] = ages[i] + 1'b1;
          end
        end
        active_n[target]      = 1'b1;
        ages_n[target]        = '0;
        voice_ready_n[target] = 1'b1;
        voice_note_n[target]  = '{status: NOTE_ON, note_number: note.note_number};
      end else if (match_hit) begin
        active_n[match_idx]      = 1'b0;
        voice_ready_n[match_idx] = 1'b1;
        voice_note_n[match_idx]  = '{status: NOTE_OFF, note_number: note.note_number};
      end
    end
  end

  // Table and output registers; reset drops everything without OFF strobes.
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        voice_note[i] <= '{status: NOTE_OFF, note_number: '0};
        ages[i]       <= '0;
      end
      voice_ready <= '0;
      active_mask <= '0;
      stolen      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        voice_note[i] <= voice_note_n[i];
        ages[i]       <= ages_n[i];
      end
      voice_ready <= voice_ready_n;
      active_mask <= active_n;
      stolen      <= stolen_n;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed note events, expected
// responses queued by the stimulus and checked by an independent monitor.
module tb_voice_allocator;
  import voice_allocator_pkg::*;

  localparam int NV = 8;

  logic                  clk = 1'b0;
  logic                  reset_l;
  note_change_t          note;
  logic                  note_ready;
  logic                  all_off;
  note_change_t          voice_note [NV];
  logic [NV-1:0]         voice_ready;
  logic [NV-1:0]         active_mask;
  logic                  stolen;

  typedef struct packed {
    logic [31:0]     due;
    logic [7:0]      ready;
    logic [7:0]      mask;
    logic            stl;
    logic [7:0][7:0] notes;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cycle       = 0;

  always #10 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  voice_allocator #(
    .NUM_VOICES (NV),
    .AGE_WIDTH  (4)
  ) dut (
    .clock_50_000_000 (clk),
    .reset_l          (reset_l),
    .note             (note),
    .note_ready       (note_ready),
    .all_off          (all_off),
    .voice_note       (voice_note),
    .voice_ready      (voice_ready),
    .active_mask      (active_mask),
    .stolen           (stolen)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0][7:0] one_note(input note_status_t st, input logic [6:0] num,
                                               input logic [7:0] ready);
    logic [7:0][7:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      if (ready[i]) n[i] = {st, num};
    end
    return n;
  endfunction

  // Drive one event at a negedge; the expected response is due one cycle later.
  task automatic applyStimulus(input logic rdy, input note_status_t st, input logic [6:0] num,
                               input logic aoff, input logic has_exp, input logic [7:0] ready,
                               input logic [7:0] mask, input logic stl,
                               input logic [7:0][7:0] notes);
    exp_t e;
    @(negedge clk);
    note.status      = st;
    note.note_number = num;
    note_ready       = rdy;
    all_off          = aoff;
    if (has_exp) begin
      e.due   = 32'(cycle + 1);
      e.ready = ready;
      e.mask  = mask;
      e.stl   = stl;
      e.notes = notes;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    note_ready = 1'b0;
    all_off    = 1'b0;
  endtask

  task automatic note_on(input logic [6:0] num, input logic [7:0] ready, input logic [7:0] mask,
                         input logic stl);
    applyStimulus(1'b1, NOTE_ON, num, 1'b0, 1'b1, ready, mask, stl, one_note(NOTE_ON, num, ready));
  endtask

  task automatic note_off(input logic [6:0] num, input logic [7:0] ready, input logic [7:0] mask);
    applyStimulus(1'b1, NOTE_OFF, num, 1'b0, 1'b1, ready, mask, 1'b0,
                  one_note(NOTE_OFF, num, ready));
  endtask

  // Monitor: check the due response, otherwise any strobe is unexpected.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0 && sb_q[0].due == 32'(cycle)) begin
        e = sb_q.pop_front();
        checkOutput("voice_ready", 64'(voice_ready), 64'(e.ready));
        checkOutput("active_mask", 64'(active_mask), 64'(e.mask));
        checkOutput("stolen", 64'(stolen), 64'(e.stl));
        for (int i = 0; i < NV; i++) begin
          if (e.ready[i]) checkOutput($sformatf("voice_note%0d", i), 64'(voice_note[i]), 64'(e.notes[i]));
        end
      end else if (voice_ready != '0 || stolen) begin
        checkOutput("spurious_strobe", 64'({voice_ready, stolen}), 64'h0);
      end
    end
  end

  initial begin
    logic [7:0][7:0] n;
    reset_l          = 1'b1;
    note_ready       = 1'b0;
    all_off          = 1'b0;
    note.status      = NOTE_OFF;
    note.note_number = '0;
    #1 reset_l = 1'b0;
    #4;
    checkOutput("reset_active_mask", 64'(active_mask), 64'h0);
    checkOutput("reset_voice_ready", 64'(voice_ready), 64'h0);
    checkOutput("reset_stolen", 64'(stolen), 64'h0);
    checkOutput("reset_voice_note", 64'({voice_note[0], voice_note[3], voice_note[7]}), 64'h0);
    repeat (2) @(negedge clk);
    reset_l = 1'b1;

    // Fill all voices, then steal the two oldest in turn.
    note_on(7'd60, 8'h01, 8'h01, 1'b0);
    note_on(7'd61, 8'h02, 8'h03, 1'b0);
    note_on(7'd62, 8'h04, 8'h07, 1'b0);
    note_on(7'd63, 8'h08, 8'h0F, 1'b0);
    note_on(7'd64, 8'h10, 8'h1F, 1'b0);
    note_on(7'd65, 8'h20, 8'h3F, 1'b0);
    note_on(7'd66, 8'h40, 8'h7F, 1'b0);
    note_on(7'd67, 8'h80, 8'hFF, 1'b0);
    note_on(7'd70, 8'h01, 8'hFF, 1'b1);
    note_on(7'd71, 8'h02, 8'hFF, 1'b1);

    // Panic with every voice sounding.
    n = '0;
    n[0] = {NOTE_OFF, 7'd70};
    n[1] = {NOTE_OFF, 7'd71};
    n[2] = {NOTE_OFF, 7'd62};
    n[3] = {NOTE_OFF, 7'd63};
    n[4] = {NOTE_OFF, 7'd64};
    n[5] = {NOTE_OFF, 7'd65};
    n[6] = {NOTE_OFF, 7'd66};
    n[7] = {NOTE_OFF, 7'd67};
    applyStimulus(1'b0, NOTE_OFF, 7'd0, 1'b1, 1'b1, 8'hFF, 8'h00, 1'b0, n);

    // OFF routing, unmatched OFF, reuse of the freed lowest voice.
    note_on(7'd60, 8'h01, 8'h01, 1'b0);
    note_on(7'd62, 8'h02, 8'h03, 1'b0);
    note_off(7'd60, 8'h01, 8'h02);
    applyStimulus(1'b1, NOTE_OFF, 7'd99, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, '0);
    @(negedge clk);
    #1 checkOutput("mask_after_off99", 64'(active_mask), 64'h02);
    note_on(7'd64, 8'h01, 8'h03, 1'b0);
    n = '0;
    n[0] = {NOTE_OFF, 7'd64};
    n[1] = {NOTE_OFF, 7'd62};
    applyStimulus(1'b0, NOTE_OFF, 7'd0, 1'b1, 1'b1, 8'h03, 8'h00, 1'b0, n);

    // Retrigger the same note reuses its voice.
    note_on(7'd60, 8'h01, 8'h01, 1'b0);
    note_on(7'd60, 8'h01, 8'h01, 1'b0);
    note_off(7'd60, 8'h01, 8'h00);

    // Voices 0, 2, 5 active; all_off beats a coincident ON 64.
    note_on(7'd60, 8'h01, 8'h01, 1'b0);
    note_on(7'd61, 8'h02, 8'h03, 1'b0);
    note_on(7'd62, 8'h04, 8'h07, 1'b0);
    note_on(7'd63, 8'h08, 8'h0F, 1'b0);
    note_on(7'd64, 8'h10, 8'h1F, 1'b0);
    note_on(7'd65, 8'h20, 8'h3F, 1'b0);
    note_off(7'd61, 8'h02, 8'h3D);
    note_off(7'd63, 8'h08, 8'h35);
    note_off(7'd64, 8'h10, 8'h25);
    n = '0;
    n[0] = {NOTE_OFF, 7'd60};
    n[2] = {NOTE_OFF, 7'd62};
    n[5] = {NOTE_OFF, 7'd65};
    applyStimulus(1'b1, NOTE_ON, 7'd64, 1'b1, 1'b1, 8'h25, 8'h00, 1'b0, n);
    @(negedge clk);
    #1 checkOutput("mask_after_panic", 64'(active_mask), 64'h00);

    // Reset mid-operation with four voices sounding.
    note_on(7'd40, 8'h01, 8'h01, 1'b0);
    note_on(7'd41, 8'h02, 8'h03, 1'b0);
    note_on(7'd42, 8'h04, 8'h07, 1'b0);
    note_on(7'd43, 8'h08, 8'h0F, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #2 reset_l = 1'b0;
    #1;
    checkOutput("midreset_active_mask", 64'(active_mask), 64'h0);
    checkOutput("midreset_voice_ready", 64'(voice_ready), 64'h0);
    checkOutput("midreset_voice_note", 64'({voice_note[0], voice_note[1], voice_note[2], voice_note[3]}), 64'h0);
    @(negedge clk);
    reset_l = 1'b1;
    note_on(7'd48, 8'h01, 8'h01, 1'b0);

    repeat (3) @(negedge clk);
    #1 checkOutput("scoreboard_drained", 64'(sb_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphony scheduler between the MIDI front end and NUM_VOICES replicated synthesis pipelines.
- Accepts one note_change_t per note_ready strobe and assigns NOTE ON events to a free voice. When no voice is free it steals the oldest voice.
- Routes NOTE OFF events to the voice holding that note number.
- Drives each pipeline's note/note_ready pair and reports occupancy.

Parameters:
- NUM_VOICES, 8, number of downstream pipelines; power of two, 2..16.
- AGE_WIDTH, 4, width of per-voice saturating age counter; must satisfy 2^AGE_WIDTH >= NUM_VOICES.

Ports:
- clock_50_000_000  input  1  system clock.
- reset_l  input  1  asynchronous active-low reset.
- note  input  note_change_t  incoming event (status ON/OFF, note_number); sampled only when note_ready=1.
- note_ready  input  1  single-cycle event strobe; at most one event per cycle.
- all_off  input  1  panic request, level-sampled each cycle.
- voice_note  output  note_change_t [NUM_VOICES]  registered per-voice note state.
- voice_ready  output  1 [NUM_VOICES]  one-cycle strobe per voice.
- active_mask  output  NUM_VOICES  bit i=1 while voice i holds a sounding note.
- stolen  output  1  one-cycle pulse when an ON event evicted a sounding voice.

Behaviour:
- Reset (async assert, sync release):
  - voice_note[i].status=OFF and voice_note[i].note_number='0 for all i.
  - voice_ready='0, active_mask='0, stolen=0, all ages=0.
- Latency:
  - All outputs are registered.
  - An event accepted in cycle t appears on voice_note and voice_ready in cycle t+1.
  - voice_ready pulses exactly one cycle.
- Internal state per voice: active bit (drives active_mask directly), note_number, age[AGE_WIDTH-1:0].
- ON event, checked in this priority order:
  1. Retrigger: an active voice already holds note_number. Reuse it: emit ON on that voice, age:=0, stolen=0.
  2. Free: lowest-index inactive voice. Set active, store the note, emit ON, age:=0.
  3. Steal: all voices active. Pick the voice with maximum age; ties go to the lowest index. Overwrite it with the new note, emit ON (the downstream ON clears the oscillator phase), age:=0, stolen=1 for one cycle.
  - In every case, every other active voice increments its age, saturating at 2^AGE_WIDTH-1.
- OFF event:
  - Match: an active voice holds note_number. Clear active, emit OFF on that voice with the same note_number, age unchanged.
  - No match: event dropped, no strobe, no state change.
  - OFF never changes other voices' ages.
- all_off:
  - Every active voice is cleared and receives an OFF strobe in the same t+1 cycle.
  - Inactive voices get no strobe.
  - all_off has priority over a coincident note_ready; that event is discarded.
- Invariants:
  - At most one voice holds a given note_number.
  - Outside all_off, at most one voice_ready bit is set per cycle.
  - voice_note[i] retains its last value between strobes; downstream muting keys off status.
- Note numbers are passed through unchanged; range checking belongs downstream.
- Reset mid-operation: all state is cleared immediately; no OFF strobes are emitted for voices lost at reset.

Decomposition:
- Shared package VOICE: typedef voice_index_t = logic[$clog2(NUM_VOICES)-1:0], constant NUM_VOICES_DEFAULT, and the ON/OFF status values reused from MIDI.
- One combinational sub-module, voice_select:
  - Inputs: active vector, note-number array, ages, query note.
  - Outputs: match_hit/match_idx, free_hit/free_idx, oldest_idx.
  - Uses priority encoders and a max-age tree with lowest-index tie-break.
- voice_allocator holds the table, age update, strobe registers and all_off handling.

Test Plan:
- Reset, then ON note 60 -> at t+1 voice_ready=8'b0000_0001, voice_note[0]={ON,60}, active_mask=8'h01.
- ONs for notes 60..67, then ON 70 -> voice 0 (age saturated/oldest) gets {ON,70}, stolen=1 for one cycle, active_mask stays 8'hFF.
- ON 60, ON 62, OFF 60 -> voice 0 strobes {OFF,60}, active_mask=8'h02; then OFF 99 -> no voice_ready, no state change.
- ON 60, then ON 60 again -> second event strobes voice 0 again with age reset, active_mask=8'h01, no second voice used.
- Voices 0, 2 and 5 active, all_off asserted together with note_ready ON 64 -> voice_ready=8'b0010_0101 all with OFF, active_mask=0, note 64 not allocated.
- Drop reset_l for one cycle while 4 voices are active -> outputs clear asynchronously, no strobes; next ON 48 goes to voice 0.
